// File: rtl/riscq_pkg.sv
// Shared definitions for the data-RAM init path: RAM geometry and loader FSM encodings.
package riscq_pkg;

    localparam int RAM_ADDR_W = 12;
    localparam int RAM_DEPTH  = 4096;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RSTHOLD = 3'd1;
    localparam state_t ST_HDR0    = 3'd2;
    localparam state_t ST_HDR1    = 3'd3;
    localparam state_t ST_DATA    = 3'd4;
    localparam state_t ST_CSUM    = 3'd5;
    localparam state_t ST_DONE    = 3'd6;
    localparam state_t ST_ERR     = 3'd7;

endpackage

// File: rtl/byte_word_packer.sv
// Packs little-endian bytes into 32-bit words; the packed word is presented
// with a one-cycle valid pulse the cycle after its fourth byte.
module byte_word_packer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_vld,
    output logic        o_lane_last,
    output logic [31:0] o_word,
    output logic        o_word_vld
);

    logic [1:0]  r_lane;
    logic [23:0] r_shift_p0;
    logic [31:0] r_word_p1;
    logic        r_word_vld_p1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lane        <= 2'd0;
            r_word_p1     <= 32'd0;
            r_word_vld_p1 <= 1'b0;
        end else begin
            r_word_vld_p1 <= 1'b0;
            if (i_clear) begin
                r_lane <= 2'd0;
            end else if (i_byte_vld) begin
                if (r_lane == 2'd3) begin
                    r_word_p1     <= {i_byte, r_shift_p0};
                    r_word_vld_p1 <= 1'b1;
                end
                r_lane <= r_lane + 2'd1;
            end
        end
    end

    // Lower three lanes are pure data and need no reset.
    always_ff @(posedge i_clk) begin
        if (i_byte_vld) begin
            case (r_lane)
                2'd0:    r_shift_p0[7:0]   <= i_byte;
                2'd1:    r_shift_p0[15:8]  <= i_byte;
                2'd2:    r_shift_p0[23:16] <= i_byte;
                default: r_shift_p0        <= r_shift_p0;
            endcase
        end
    end

    assign o_lane_last = (r_lane == 2'd3);
    assign o_word      = r_word_p1;
    assign o_word_vld  = r_word_vld_p1;

endmodule

// File: rtl/dram_init_loader.sv
// Loads the data RAM from a framed host byte stream while holding the CPU in reset;
// releases reset only after a complete frame with a matching checksum.
module dram_init_loader
    import riscq_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int DEPTH       = RAM_DEPTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    output logic                  o_cpu_rst,
    output logic                  o_init_we,
    output logic [RAM_ADDR_W-1:0] o_init_waddr,
    output logic [31:0]           o_init_wdata,
    output logic                  o_init_done,
    output logic                  o_busy,
    output logic                  o_err
);

    localparam int             TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [16:0]    DEPTH_L = 17'(DEPTH);

    function automatic logic [7:0] f_csum_add(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_n_lo;
    logic [15:0]           r_n_words;
    logic [15:0]           r_acc_words;
    logic [RAM_ADDR_W-1:0] r_waddr;
    logic [7:0]            r_csum;
    logic [TO_W-1:0]       r_to_cnt;
    logic                  r_cpu_rst;

    logic        w_rx_ready;
    logic        w_accept;
    logic        w_data_byte;
    logic        w_lane_last;
    logic        w_last_word;
    logic        w_to_hit;
    logic        w_restart;
    logic [15:0] w_hdr_n;
    logic [31:0] w_word;
    logic        w_word_vld;

    assign w_rx_ready  = (r_state == ST_HDR0) || (r_state == ST_HDR1) ||
                         (r_state == ST_DATA) || (r_state == ST_CSUM);
    assign w_accept    = i_rx_valid && w_rx_ready;
    assign w_data_byte = w_accept && (r_state == ST_DATA);
    assign w_hdr_n     = {i_rx_data, r_n_lo};
    assign w_last_word = w_data_byte && w_lane_last && ((r_acc_words + 16'd1) == r_n_words);
    assign w_to_hit    = w_rx_ready && !w_accept && (r_to_cnt == TO_LAST);
    assign w_restart   = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                     (r_state == ST_ERR));

    byte_word_packer u_packer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (r_state == ST_RSTHOLD),
        .i_byte      (i_rx_data),
        .i_byte_vld  (w_data_byte),
        .o_lane_last (w_lane_last),
        .o_word      (w_word),
        .o_word_vld  (w_word_vld)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (i_start) w_state_nxt = ST_RSTHOLD;
            end
            ST_RSTHOLD: w_state_nxt = ST_HDR0;
            ST_HDR0: begin
                if (w_accept)      w_state_nxt = ST_HDR1;
                else if (w_to_hit) w_state_nxt = ST_ERR;
            end
            ST_HDR1: begin
                if (w_accept) begin
                    if ({1'b0, w_hdr_n} > DEPTH_L) w_state_nxt = ST_ERR;
                    else if (w_hdr_n == 16'd0)     w_state_nxt = ST_CSUM;
                    else                           w_state_nxt = ST_DATA;
                end else if (w_to_hit) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_DATA: begin
                if (w_last_word)   w_state_nxt = ST_CSUM;
                else if (w_to_hit) w_state_nxt = ST_ERR;
            end
            ST_CSUM: begin
                if (w_accept)      w_state_nxt = (i_rx_data == r_csum) ? ST_DONE : ST_ERR;
                else if (w_to_hit) w_state_nxt = ST_ERR;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Idle timer restarts on every accepted byte and every state change.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_to_cnt <= '0;
        else if (!w_rx_ready || w_accept || (w_state_nxt != r_state))
            r_to_cnt <= '0;
        else
            r_to_cnt <= r_to_cnt + TO_W'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_n_lo      <= 8'd0;
            r_n_words   <= 16'd0;
            r_acc_words <= 16'd0;
            r_csum      <= 8'd0;
        end else if (r_state == ST_RSTHOLD) begin
            r_acc_words <= 16'd0;
            r_csum      <= 8'd0;
        end else begin
            if (w_accept && (r_state == ST_HDR0)) r_n_lo    <= i_rx_data;
            if (w_accept && (r_state == ST_HDR1)) r_n_words <= w_hdr_n;
            if (w_data_byte) begin
                r_csum <= f_csum_add(r_csum, i_rx_data);
                if (w_lane_last) r_acc_words <= r_acc_words + 16'd1;
            end
        end
    end

    // Write address saturates at the top word rather than wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_waddr <= '0;
        else if (r_state == ST_RSTHOLD)
            r_waddr <= '0;
        else if (w_word_vld && (r_waddr != '1))
            r_waddr <= r_waddr + RAM_ADDR_W'(1);
    end

    // CPU reset is released one cycle after DONE is entered, and re-asserted on restart.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                r_cpu_rst <= 1'b1;
        else if (w_restart)          r_cpu_rst <= 1'b1;
        else if (r_state == ST_DONE) r_cpu_rst <= 1'b0;
    end

    assign o_rx_ready   = w_rx_ready;
    assign o_cpu_rst    = r_cpu_rst;
    assign o_init_we    = w_word_vld;
    assign o_init_waddr = r_waddr;
    assign o_init_wdata = w_word;
    assign o_init_done  = (r_state == ST_DONE);
    assign o_err        = (r_state == ST_ERR);
    assign o_busy       = (r_state == ST_RSTHOLD) || w_rx_ready;

endmodule
